// File: rtl/rpll_phase_sweep_ctrl.sv
// Dynamic phase sweep controller for a Gowin rPLL: steps PSDA through 0..15, counts
// per-channel phase-detector hits at each step and reports the best step per channel.
module rpll_phase_sweep_ctrl #(
    parameter int         N_CH          = 1,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         SAMPLE_CYCLES = 256,
    parameter int         DUTY_OFFS     = 8,
    parameter logic [3:0] PS_INIT       = 4'd0,
    parameter int         CNT_W         = $clog2(SAMPLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic [3:0]              manual_psda,
    input  logic                    pll_lock,
    input  logic [N_CH-1:0]         pd_in,
    output logic [3:0]              psda,
    output logic [3:0]              dutyda,
    output logic                    busy,
    output logic                    done,
    output logic                    result_valid,
    output logic [4*N_CH-1:0]       best_psda,
    output logic [CNT_W*N_CH-1:0]   best_score
);
    localparam int CYC_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] SAMPLE_LAST = CYC_W'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]       DUTY_OFFS4  = 4'(DUTY_OFFS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        SAMPLE    = 3'd3,
        EVAL      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 psda_q, psda_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       valid_q, valid_d;
    logic [CYC_W-1:0]           cyc_q, cyc_d;
    logic [N_CH-1:0][CNT_W-1:0] hits_q, hits_d;
    logic [N_CH-1:0][CNT_W-1:0] run_sc_q, run_sc_d;
    logic [N_CH-1:0][CNT_W-1:0] out_sc_q, out_sc_d;
    logic [N_CH-1:0][3:0]       run_ps_q, run_ps_d;
    logic [N_CH-1:0][3:0]       out_ps_q, out_ps_d;

    logic begin_sweep, lose_lock;
    logic clr_hits, clr_run, acc_en, eval_en, load_out;

    always_comb begin
        state_d     = state_q;
        psda_d      = psda_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        cyc_d       = cyc_q;
        begin_sweep = 1'b0;
        lose_lock   = 1'b0;
        clr_hits    = 1'b0;
        clr_run     = 1'b0;
        acc_en      = 1'b0;
        eval_en     = 1'b0;
        load_out    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mode == 2'd2) begin
                    psda_d = manual_psda;
                end else if (start) begin
                    begin_sweep = 1'b1;
                end
            end
            WAIT_LOCK: begin
                cyc_d    = '0;
                clr_hits = 1'b1;
                if (pll_lock) state_d = SETTLE;
            end
            SETTLE: begin
                if (!pll_lock) begin
                    lose_lock = 1'b1;
                end else if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (!pll_lock) begin
                    lose_lock = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (cyc_q == SAMPLE_LAST) begin
                        cyc_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            EVAL: begin
                if (!pll_lock) begin
                    lose_lock = 1'b1;
                end else begin
                    eval_en  = 1'b1;
                    clr_hits = 1'b1;
                    if (psda_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        psda_d  = psda_q + 4'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                load_out = 1'b1;
                valid_d  = 1'b1;
                if (mode == 2'd1) begin
                    begin_sweep = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by start acceptance in IDLE and the automatic restart in continuous mode.
        if (begin_sweep) begin
            psda_d   = 4'd0;
            busy_d   = 1'b1;
            cyc_d    = '0;
            clr_hits = 1'b1;
            clr_run  = 1'b1;
            state_d  = pll_lock ? SETTLE : WAIT_LOCK;
        end

        // Lock loss keeps psda and the running bests; only the current step is redone.
        if (lose_lock) begin
            state_d  = WAIT_LOCK;
            cyc_d    = '0;
            clr_hits = 1'b1;
        end
    end

    always_comb begin
        hits_d   = hits_q;
        run_sc_d = run_sc_q;
        run_ps_d = run_ps_q;
        out_sc_d = out_sc_q;
        out_ps_d = out_ps_q;
        for (int i = 0; i < N_CH; i++) begin
            if (acc_en) hits_d[i] = hits_q[i] + CNT_W'(pd_in[i]);
            // Strict compare: on a tie the earlier (lower) step wins.
            if (eval_en && (hits_q[i] > run_sc_q[i])) begin
                run_sc_d[i] = hits_q[i];
                run_ps_d[i] = psda_q;
            end
            if (clr_hits) hits_d[i] = '0;
            if (clr_run) begin
                run_sc_d[i] = '0;
                run_ps_d[i] = '0;
            end
            if (load_out) begin
                out_sc_d[i] = run_sc_q[i];
                out_ps_d[i] = run_ps_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            psda_q   <= PS_INIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            cyc_q    <= '0;
            hits_q   <= '0;
            run_sc_q <= '0;
            run_ps_q <= '0;
            out_sc_q <= '0;
            out_ps_q <= '0;
        end else begin
            state_q  <= state_d;
            psda_q   <= psda_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            cyc_q    <= cyc_d;
            hits_q   <= hits_d;
            run_sc_q <= run_sc_d;
            run_ps_q <= run_ps_d;
            out_sc_q <= out_sc_d;
            out_ps_q <= out_ps_d;
        end
    end

    assign psda         = psda_q;
    assign dutyda       = psda_q + DUTY_OFFS4;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = valid_q;
    assign best_psda    = out_ps_q;
    assign best_score   = out_sc_q;

endmodule
